// File: rtl/spi_dac_receiver.sv
// SPI slave input register feeding a DAC register that loads on the bLDAC strobe.
// Define SPI_RX_SDO_EN to add the SDO readback shifter and its port.
module spi_dac_receiver #(
  parameter int spi_length  = 16,
  parameter int sync_stages = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bCS,
  input  logic                  SCK,
  input  logic                  SDI,
  input  logic                  bLDAC,
  output logic [spi_length-1:0] rx_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [spi_length-1:0] dac_out,
  output logic                  dac_update
`ifdef SPI_RX_SDO_EN
  ,
  output logic                  SDO
`endif
);

  localparam int            CW  = $clog2(spi_length + 2);
  localparam logic [CW-1:0] LEN = CW'(spi_length);
  localparam logic [CW-1:0] SAT = CW'(spi_length + 1);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT, CHECK} state_t;

  state_t                 r_state;
  state_t                 w_next_state;
  logic [sync_stages-1:0] r_cs_sync;
  logic [sync_stages-1:0] r_sck_sync;
  logic [sync_stages-1:0] r_sdi_sync;
  logic [sync_stages-1:0] r_ldac_sync;
  logic                   r_cs_d;
  logic                   r_sck_d;
  logic                   r_ldac_d;
  logic [spi_length-1:0]  r_shift;
  logic [CW-1:0]          r_count;
  logic                   w_cs;
  logic                   w_sck;
  logic                   w_sdi;
  logic                   w_ldac;
  logic                   w_cs_rise;
  logic                   w_cs_fall;
  logic                   w_sck_rise;
  logic                   w_ldac_fall;
  logic                   w_clear;
  logic                   w_shift_en;
  logic                   w_capture;
  logic                   w_reject;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cs_sync   <= '0;
      r_sck_sync  <= '0;
      r_sdi_sync  <= '0;
      r_ldac_sync <= '0;
      r_cs_d      <= 1'b0;
      r_sck_d     <= 1'b0;
      r_ldac_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[sync_stages-2:0], bCS};
      r_sck_sync  <= {r_sck_sync[sync_stages-2:0], SCK};
      r_sdi_sync  <= {r_sdi_sync[sync_stages-2:0], SDI};
      r_ldac_sync <= {r_ldac_sync[sync_stages-2:0], bLDAC};
      r_cs_d      <= w_cs;
      r_sck_d     <= w_sck;
      r_ldac_d    <= w_ldac;
    end
  end

  assign w_cs        = r_cs_sync[sync_stages-1];
  assign w_sck       = r_sck_sync[sync_stages-1];
  assign w_sdi       = r_sdi_sync[sync_stages-1];
  assign w_ldac      = r_ldac_sync[sync_stages-1];
  assign w_cs_rise   = w_cs & ~r_cs_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_sck_rise  = w_sck & ~r_sck_d;
  assign w_ldac_fall = ~w_ldac & r_ldac_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= WAIT_IDLE;
    else     r_state <= w_next_state;
  end

  // WAIT_IDLE keeps a frame already in progress at reset release from being captured.
  always_comb begin
    w_next_state = r_state;
    w_clear      = 1'b0;
    w_shift_en   = 1'b0;
    w_capture    = 1'b0;
    w_reject     = 1'b0;
    case (r_state)
      WAIT_IDLE: if (w_cs) w_next_state = IDLE;
      IDLE: begin
        if (w_cs_fall) begin
          w_clear      = 1'b1;
          w_next_state = SHIFT;
        end
      end
      SHIFT: begin
        if (w_cs_rise)              w_next_state = CHECK;
        else if (w_sck_rise && !w_cs) w_shift_en = 1'b1;
      end
      CHECK: begin
        w_next_state = IDLE;
        if (r_count == LEN) w_capture = 1'b1;
        else                w_reject  = 1'b1;
      end
      default: w_next_state = WAIT_IDLE;
    endcase
  end

  // The counter runs one past the frame length so an overlong frame is still rejected.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shift     <= '0;
      r_count     <= '0;
      rx_data     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      dac_out     <= '0;
      dac_update  <= 1'b0;
    end else begin
      if (w_clear) begin
        r_shift <= '0;
        r_count <= '0;
      end else if (w_shift_en) begin
        if (r_count < LEN) r_shift <= {r_shift[spi_length-2:0], w_sdi};
        if (r_count < SAT) r_count <= r_count + 1'b1;
      end
      if (w_capture) rx_data <= r_shift;
      frame_valid <= w_capture;
      frame_err   <= w_reject;
      dac_update  <= w_ldac_fall;
      if (w_ldac_fall) dac_out <= w_capture ? r_shift : rx_data;
    end
  end

`ifdef SPI_RX_SDO_EN
  logic [spi_length-1:0] r_readback;
  logic                  w_sck_fall;

  assign w_sck_fall = ~w_sck & r_sck_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      r_readback <= '0;
    else if (w_cs_fall)           r_readback <= rx_data;
    else if (w_sck_fall && !w_cs) r_readback <= {r_readback[spi_length-2:0], 1'b0};
  end

  assign SDO = r_readback[spi_length-1] & ~w_cs;
`endif

endmodule
